// File: rtl/teachee_sample_packetizer.sv
// ---------------------------------------------------------------------------
// teachee_sample_packetizer
//
// Packs one 32-bit sample pair (ch0 = [31:16], ch1 = [15:0]) into a byte
// frame for the FTDI byte stream:
//    SYNC_BYTE, SEQ, ch0[15:8], ch0[7:0], ch1[15:8], ch1[7:0] [, CHECKSUM]
// The SEQ byte is an 8-bit frame counter. It starts at SEQ_INIT, advances
// once per completed frame, and wraps from 8'hFF to 8'h00.
//
// Build option:
//    TEACHEE_PKT_CHECKSUM_EN  when defined, adds a 7th byte. This byte is the
//                             XOR of bytes 1..5 (SEQ through ch1[7:0]).
//
// Ports:
//    clk       in   single clock (FTDI sink domain)
//    rst_n     in   asynchronous active-low reset
//    s_tdata   in   sample pair
//    s_tvalid  in   sample pair valid
//    s_tready  out  registered; high only while idle
//    m_tdata   out  frame byte
//    m_tvalid  out  frame byte valid
//    m_tready  in   downstream accepts a byte
//    busy      out  high while a frame is being emitted
//
// state | meaning
// IDLE  | waiting for a sample pair; s_tready high (from the first edge on)
// EMIT  | streaming frame bytes; s_tdata ignored
// ---------------------------------------------------------------------------
module teachee_sample_packetizer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] SEQ_INIT  = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        busy
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_EMIT = 1'b1;

`ifdef TEACHEE_PKT_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd6;
`else
    localparam logic [2:0] LAST_IDX = 3'd5;
`endif

    logic        state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  seq_q, seq_d;
    logic [31:0] pair_q, pair_d;
    logic [7:0]  m_tdata_q, m_tdata_d;
    logic        m_tvalid_q, m_tvalid_d;
    logic        s_tready_q, s_tready_d;
    logic        s_hs;
    logic        m_hs;

    // seq_q changes only when a frame completes, so during EMIT it already
    // holds the sequence number that was current at acceptance.
    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [31:0] pair,
                                              input logic [7:0]  seq);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = seq;
            3'd2:    b = pair[31:24];
            3'd3:    b = pair[23:16];
            3'd4:    b = pair[15:8];
            3'd5:    b = pair[7:0];
`ifdef TEACHEE_PKT_CHECKSUM_EN
            3'd6:    b = seq ^ pair[31:24] ^ pair[23:16] ^ pair[15:8] ^ pair[7:0];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign s_hs = s_tvalid & s_tready_q;
    assign m_hs = m_tvalid_q & m_tready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        seq_d      = seq_q;
        pair_d     = pair_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        s_tready_d = s_tready_q;
        case (state_q)
            ST_IDLE: begin
                // Raises s_tready on the first edge after reset release.
                s_tready_d = 1'b1;
                if (s_hs) begin
                    pair_d     = s_tdata;
                    idx_d      = 3'd0;
                    m_tdata_d  = SYNC_BYTE;
                    m_tvalid_d = 1'b1;
                    s_tready_d = 1'b0;
                    state_d    = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (m_hs) begin
                    if (idx_q == LAST_IDX) begin
                        // m_tvalid drops and s_tready rises on the same
                        // edge, which leaves one bubble cycle between frames.
                        idx_d      = 3'd0;
                        m_tvalid_d = 1'b0;
                        s_tready_d = 1'b1;
                        seq_d      = seq_q + 8'd1;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        m_tdata_d = frame_byte(idx_q + 3'd1, pair_q, seq_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            seq_q      <= SEQ_INIT;
            pair_q     <= 32'h0;
            m_tdata_q  <= 8'h00;
            m_tvalid_q <= 1'b0;
            s_tready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            pair_q     <= pair_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            s_tready_q <= s_tready_d;
        end
    end

    assign s_tready = s_tready_q;
    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign busy     = (state_q == ST_EMIT);

endmodule

// File: tb/tb_teachee_sample_packetizer.sv
`timescale 1ns/1ps
module tb_teachee_sample_packetizer;

    localparam logic [7:0] SYNC = 8'hA5;
`ifdef TEACHEE_PKT_CHECKSUM_EN
    localparam int FRAME_LEN = 7;
`else
    localparam int FRAME_LEN = 6;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        busy;

    always #5 clk = ~clk;

    teachee_sample_packetizer #(
        .SYNC_BYTE (8'hA5),
        .SEQ_INIT  (8'h00)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .busy     (busy)
    );

    typedef struct {
        logic [31:0] data;
        bit          toggle;
        logic [47:0] exp;
        logic [7:0]  ck;
    } vec_t;

    vec_t        vecs[5];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [7:0]  byte_q[$];
    int          cyc_q[$];
    bit          toggle_mode = 1'b0;
    bit          stall_pend  = 1'b0;
    logic [7:0]  stall_data  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [31:0] d, input logic [7:0] seq, input int j);
        case (j)
            0:       return SYNC;
            1:       return seq;
            2:       return d[31:24];
            3:       return d[23:16];
            4:       return d[15:8];
            5:       return d[7:0];
            6:       return seq ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
            default: return 8'h00;
        endcase
    endfunction

    // Byte collector and stall-stability checker, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_valid_held", m_tvalid, 1);
                check("stall_data_held", m_tdata, stall_data);
            end
            stall_pend = m_tvalid && !m_tready;
            stall_data = m_tdata;
            if (m_tvalid && m_tready) begin
                byte_q.push_back(m_tdata);
                cyc_q.push_back(cyc);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (toggle_mode) m_tready = ~m_tready;
    endtask

    task automatic send(input logic [31:0] d, input bit keep_valid);
        int g;
        g = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        while (!s_tready && g < 50) begin
            cycle();
            g++;
        end
        check("accept_timeout", (g < 50), 1);
        cycle();
        if (!keep_valid) s_tvalid = 1'b0;
        s_tdata = ~d;
        @(negedge clk);
        check("latency_valid", m_tvalid, 1);
        check("latency_sync", m_tdata, SYNC);
        check("busy_emit", busy, 1);
        check("s_tready_emit", s_tready, 0);
    endtask

    task automatic wait_bytes(input int n);
        int g;
        g = 0;
        while (byte_q.size() < n && g < 400) begin
            cycle();
            g++;
        end
        check("frame_timeout", (byte_q.size() >= n), 1);
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_bubble_mvalid"}, m_tvalid, 0);
        check({tag, "_bubble_sready"}, s_tready, 1);
        check({tag, "_bubble_busy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pairs[3];
        logic [7:0]  b;
        int          first_cyc;
        int          last_cyc;

        vecs[0] = '{32'h1234_ABCD, 1'b0, 48'hA5_00_12_34_AB_CD, 8'h40};
        vecs[1] = '{32'h1234_ABCD, 1'b1, 48'hA5_01_12_34_AB_CD, 8'h41};
        vecs[2] = '{32'h0000_0000, 1'b0, 48'hA5_02_00_00_00_00, 8'h02};
        vecs[3] = '{32'hFFFF_FFFF, 1'b1, 48'hA5_03_FF_FF_FF_FF, 8'h03};
        vecs[4] = '{32'h8001_7FFE, 1'b0, 48'hA5_04_80_01_7F_FE, 8'h04};

        rst_n    = 1'b0;
        s_tdata  = 32'h0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 8'h00);
        check("rst_s_tready", s_tready, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("release_s_tready_low", s_tready, 0);
        cycle();
        check("release_s_tready_high", s_tready, 1);
        check("release_m_tvalid", m_tvalid, 0);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            toggle_mode = vecs[i].toggle;
            m_tready    = 1'b1;
            send(vecs[i].data, 1'b0);
            wait_bytes(FRAME_LEN);
            for (int j = 0; j < 6; j++) begin
                b = byte_q.pop_front();
                check($sformatf("vec%0d_byte%0d", i, j), b, vecs[i].exp[47-8*j -: 8]);
            end
`ifdef TEACHEE_PKT_CHECKSUM_EN
            b = byte_q.pop_front();
            check($sformatf("vec%0d_checksum", i), b, vecs[i].ck);
`endif
            check_bubble($sformatf("vec%0d", i));
            byte_q.delete();
            cyc_q.delete();
        end
        toggle_mode = 1'b0;
        m_tready    = 1'b1;

        // Reset while byte index 3 is presented; the frame must not resume.
        send(32'hDEAD_BEEF, 1'b0);
        cycle();
        cycle();
        cycle();
        check("pre_reset_byte3", m_tdata, 8'hAD);
        rst_n = 1'b0;
        #1;
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_m_tdata", m_tdata, 8'h00);
        check("midrst_s_tready", s_tready, 0);
        check("midrst_busy", busy, 0);
        cycle();
        cycle();
        byte_q.delete();
        cyc_q.delete();
        rst_n = 1'b1;
        cycle();
        check("postrst_s_tready", s_tready, 1);
        check("postrst_no_resume", m_tvalid, 0);
        cycle();
        check("postrst_no_resume2", m_tvalid, 0);

        // Back-to-back pairs with s_tvalid held high throughout
        pairs[0] = 32'h1122_3344;
        pairs[1] = 32'h5566_7788;
        pairs[2] = 32'h99AA_BBCC;
        send(pairs[0], 1'b1);
        send(pairs[1], 1'b1);
        send(pairs[2], 1'b0);
        wait_bytes(3 * FRAME_LEN);
        check("b2b_byte_count", byte_q.size(), 3 * FRAME_LEN);
        last_cyc = 0;
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < FRAME_LEN; j++) begin
                b = byte_q.pop_front();
                check($sformatf("b2b_f%0d_byte%0d", f, j), b, exp_byte(pairs[f], 8'(f), j));
                if (j == 0) begin
                    first_cyc = cyc_q.pop_front();
                    if (f > 0) check($sformatf("b2b_gap_f%0d", f), first_cyc - last_cyc, 2);
                end else begin
                    last_cyc = cyc_q.pop_front();
                end
            end
        end
        check_bubble("b2b");
        byte_q.delete();
        cyc_q.delete();

        // Sequence wrap: 257 frames from reset, the last one carries SEQ 00
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        byte_q.delete();
        cyc_q.delete();
        for (int k = 0; k < 257; k++) begin
            send({k[15:0], ~k[15:0]}, 1'b0);
            wait_bytes(FRAME_LEN);
            b = byte_q.pop_front();
            check("wrap_sync", b, SYNC);
            b = byte_q.pop_front();
            if (k == 256) check("wrap_seq_frame257", b, 8'h00);
            else          check($sformatf("wrap_seq_%0d", k), b, k[7:0]);
            byte_q.delete();
            cyc_q.delete();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
